param_divider: RTL and testbench
================================

PARAM_DIVIDER -- requirements
Module: param_divider

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the dividend and quotient width (legal range 4..64).
REQ-002 The block SHALL have parameter VW, default 16, giving the divisor and remainder width (legal range 2..DW).
REQ-003 The block SHALL have port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a division, sampled only in IDLE.
REQ-006 The block SHALL have port signed_op, input, 1 bit: 1 selects two's-complement operation, sampled with start.
REQ-007 The block SHALL have port inDividend, input, DW bits: dividend, captured when start is accepted.
REQ-008 The block SHALL have port inDivisor, input, VW bits: divisor, captured when start is accepted.
REQ-009 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-011 The block SHALL have port Quotient, output, DW bits: result quotient.
REQ-012 The block SHALL have port Remainder, output, VW bits: result remainder.
REQ-013 The block SHALL have port div_by_zero, output, 1 bit: high with done when the captured divisor was 0; held with the results.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after DW iterations; DONE->IDLE unconditionally after one cycle.
REQ-015 The block SHALL perform restoring division, one quotient bit per RUN cycle, MSB first, using a VW+1-bit partial-remainder subtraction; the quotient bit is 1 when the difference is non-negative.
REQ-016 The block SHALL assert done exactly DW clock edges after the edge that accepted start, for one cycle only.
REQ-017 The block SHALL hold Quotient, Remainder and div_by_zero stable from done until the next accepted start completes; they SHALL NOT change during RUN.
REQ-018 The block SHALL ignore start while busy is high, without disturbing the operation in progress.
REQ-019 When the captured divisor is 0, the block SHALL skip RUN (IDLE->DONE on the accepting edge, done one edge later) and produce Quotient all ones, Remainder = inDividend[VW-1:0], div_by_zero=1.
REQ-020 For a non-zero divisor, div_by_zero SHALL be 0, and Quotient*divisor+Remainder SHALL equal the dividend, with Remainder magnitude < divisor magnitude.
REQ-021 A start asserted in the same cycle that done is high SHALL be ignored; start is accepted only in IDLE.

Reset
REQ-022 Asserting reset SHALL immediately force IDLE, busy=0, done=0, div_by_zero=0, Quotient=0, Remainder=0 and the iteration counter to 0, including mid-RUN (operation aborted, no done).
REQ-023 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-024 With macro PARAM_DIVIDER_SIGNED_EN defined, signed_op=1 SHALL convert the operands to magnitudes at capture, truncate the quotient toward zero, give the remainder the sign of the dividend, and wrap -2^(DW-1)/-1 to -2^(DW-1) with div_by_zero=0, using the same latency as unsigned.
REQ-025 With PARAM_DIVIDER_SIGNED_EN undefined, signed_op SHALL be ignored, all operations SHALL be unsigned, and no sign-handling logic SHALL be present.

Verification
REQ-026 Scenario unsigned: DW=32/VW=16, start with 100/7 -> done after 32 edges, Quotient=14, Remainder=2, div_by_zero=0.
REQ-027 Scenario max operands: 0xFFFFFFFF/0xFFFF -> Quotient=0x00010001, Remainder=0x0000.
REQ-028 Scenario divide by zero: 0x000004D2/0 -> done 1 edge after accept, Quotient=0xFFFFFFFF, Remainder=0x04D2, div_by_zero=1.
REQ-029 Scenario signed (macro defined): signed_op=1, -7/2 -> Quotient=0xFFFFFFFD, Remainder=0xFFFF; 0x80000000/0xFFFF -> Quotient=0x80000000, Remainder=0.
REQ-030 Scenario abort: reset pulsed 10 cycles into RUN -> busy=0 and outputs 0 immediately, no done; a new start with 9/3 then yields Quotient=3, Remainder=0.
REQ-031 Scenario busy protection: start re-pulsed with 50/5 during a 100/7 RUN -> results remain 14/2 and exactly one done pulse occurs.

Source files
------------

// File: rtl/param_divider.sv
// rtl/param_divider.sv - restoring divider, one quotient bit per clock, DW-cycle latency.
// Define PARAM_DIVIDER_SIGNED_EN to enable two's-complement operation via signed_op.
module param_divider #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          signed_op,
  input  logic [DW-1:0] inDividend,
  input  logic [VW-1:0] inDivisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] Quotient,
  output logic [VW-1:0] Remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [DW-1:0] work;      // dividend shifts out of the top, quotient bits shift in at the bottom
  logic [VW-1:0] dvs;
  logic [VW-1:0] prem;
  logic [CW-1:0] cnt;
  logic          zero_div;

  logic [VW:0]   trial;
  logic [VW+1:0] diff;
  logic          qbit;
  logic [VW-1:0] prem_nx;
  logic [DW-1:0] work_nx;
  logic [DW-1:0] mag_dvd;
  logic [VW-1:0] mag_dvs;
  logic [DW-1:0] res_q;
  logic [VW-1:0] res_r;

  always_comb begin
    trial   = {prem, work[DW-1]};
    diff    = {1'b0, trial} - {2'b00, dvs};
    qbit    = ~diff[VW+1];
    prem_nx = qbit ? diff[VW-1:0] : trial[VW-1:0];
    work_nx = {work[DW-2:0], qbit};
  end

`ifdef PARAM_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic sgn_dvd;
  logic sgn_dvs;

  always_comb begin
    sgn_dvd = signed_op & inDividend[DW-1];
    sgn_dvs = signed_op & inDivisor[VW-1];
    mag_dvd = sgn_dvd ? (~inDividend + 1'b1) : inDividend;
    mag_dvs = sgn_dvs ? (~inDivisor + 1'b1) : inDivisor;
    res_q   = neg_q ? (~work_nx + 1'b1) : work_nx;
    res_r   = neg_r ? (~prem_nx + 1'b1) : prem_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start && !done) begin
      neg_q <= sgn_dvd ^ sgn_dvs;
      neg_r <= sgn_dvd;
    end
  end
`else
  always_comb begin
    mag_dvd = inDividend;
    mag_dvs = inDivisor;
    res_q   = work_nx;
    res_r   = prem_nx;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      cnt         <= '0;
      work        <= '0;
      dvs         <= '0;
      prem        <= '0;
      zero_div    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // a zero-divide done pulse lands in IDLE, so start is also gated on done
          if (start && !done) begin
            busy <= 1'b1;
            cnt  <= '0;
            prem <= '0;
            if (inDivisor == '0) begin
              zero_div <= 1'b1;
              work     <= inDividend;
              state    <= DONE;
            end else begin
              zero_div <= 1'b0;
              work     <= mag_dvd;
              dvs      <= mag_dvs;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          work <= work_nx;
          prem <= prem_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            state       <= DONE;
            done        <= 1'b1;
            Quotient    <= res_q;
            Remainder   <= res_r;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
          if (zero_div) begin
            done        <= 1'b1;
            Quotient    <= '1;
            Remainder   <= work[VW-1:0];
            div_by_zero <= 1'b1;
          end else begin
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_divider.sv
// tb/tb_param_divider.sv - scoreboard bench for param_divider at DW=32, VW=16.
module tb_param_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] in_dividend = '0;
  logic [15:0] in_divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int errors = 0;
  int done_cnt = 0;

  param_divider #(.DW(32), .VW(16)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .signed_op(signed_op),
    .inDividend(in_dividend),
    .inDivisor(in_divisor),
    .busy(busy),
    .done(done),
    .Quotient(quotient),
    .Remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input bit s);
    exp_t e;
    longint sa;
    longint sb;
    if (b == 16'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a[15:0];
      e.dz = 1'b1;
      return e;
    end
    e.dz = 1'b0;
`ifdef PARAM_DIVIDER_SIGNED_EN
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.q = 32'(sa / sb);
      e.r = 16'(sa % sb);
      return e;
    end
`endif
    sa = longint'(a);
    sb = longint'(b);
    e.q = 32'(sa / sb);
    e.r = 16'(sa % sb);
    return e;
  endfunction

  task automatic check_result(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++; errors++;
      $display("FAIL %s: scoreboard empty at done", name);
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if (quotient !== e.q) begin errors++; $display("FAIL %s quotient: got %h exp %h", name, quotient, e.q); end
    vectors++;
    if (remainder !== e.r) begin errors++; $display("FAIL %s remainder: got %h exp %h", name, remainder, e.r); end
    vectors++;
    if (div_by_zero !== e.dz) begin errors++; $display("FAIL %s div_by_zero: got %b exp %b", name, div_by_zero, e.dz); end
  endtask

  task automatic do_div(input string name, input logic [31:0] a, input logic [15:0] b, input bit s);
    int lat;
    int exp_lat;
    exp_q.push_back(model(a, b, s));
    exp_lat = (b == 16'd0) ? 1 : 32;
    @(negedge clock);
    in_dividend = a; in_divisor = b; signed_op = s; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept: got %b exp 1", name, busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clock); #1; lat++;
    end
    vectors++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s latency: got %0d exp %0d", name, lat, exp_lat); end
    check_result(name);
    @(posedge clock); #1;
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b exp 0", name, done); end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%h r=%h exp all 0", busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [31:0] a;
    logic [15:0] b;
    do_div("u_100_7", 32'd100, 16'd7, 1'b0);
    do_div("u_max", 32'hFFFF_FFFF, 16'hFFFF, 1'b0);
    do_div("u_small_big", 32'd5, 16'd9, 1'b0);
    do_div("u_div1", 32'hDEAD_BEEF, 16'd1, 1'b0);
    do_div("u_msb_ignored", 32'hFFFF_FFF9, 16'h0002, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = 16'($urandom_range(1, (i < 2) ? 255 : 65535));
      do_div("u_rand", a, b, 1'b0);
    end
  endtask

  task automatic test_div_by_zero;
    do_div("dz_1234", 32'h0000_04D2, 16'd0, 1'b0);
    do_div("dz_recover", 32'd77, 16'd10, 1'b0);
  endtask

`ifdef PARAM_DIVIDER_SIGNED_EN
  task automatic test_signed;
    do_div("s_m7_2", 32'hFFFF_FFF9, 16'd2, 1'b1);
    do_div("s_wrap", 32'h8000_0000, 16'hFFFF, 1'b1);
    do_div("s_7_m2", 32'd7, 16'hFFFE, 1'b1);
    do_div("s_m100_m7", 32'hFFFF_FF9C, 16'hFFF9, 1'b1);
    do_div("s_dz", 32'hFFFF_FF00, 16'd0, 1'b1);
  endtask
`endif

  task automatic test_abort;
    int snap;
    @(negedge clock);
    in_dividend = 32'd100; in_divisor = 16'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b dz=%b q=%h r=%h exp all 0", busy, done, div_by_zero, quotient, remainder);
    end
    snap = done_cnt;
    @(negedge clock); reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    vectors++;
    if (done_cnt != snap) begin errors++; $display("FAIL abort_no_done: got %0d pulses exp 0", done_cnt - snap); end
    do_div("abort_9_3", 32'd9, 16'd3, 1'b0);
  endtask

  task automatic test_back_to_back;
    int snap;
    int lat;
    logic [31:0] q_prev;
    q_prev = quotient;
    snap = done_cnt;
    exp_q.push_back(model(32'd100, 16'd7, 1'b0));
    @(negedge clock);
    in_dividend = 32'd100; in_divisor = 16'd7; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    in_dividend = 32'd50; in_divisor = 16'd5; start = 1'b1;
    @(negedge clock); start = 1'b0;
    vectors++;
    if (quotient !== q_prev) begin errors++; $display("FAIL busy_hold_quotient: got %h exp %h", quotient, q_prev); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clock); #1; lat++; end
    vectors++;
    if (done !== 1'b1) begin errors++; $display("FAIL busy_timeout: got done=%b exp 1", done); end
    check_result("busy_protect");
    // start during the done cycle must be dropped
    in_dividend = 32'd50; in_divisor = 16'd5; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    vectors++;
    if (done_cnt - snap != 1) begin errors++; $display("FAIL busy_done_count: got %0d exp 1", done_cnt - snap); end
    vectors++;
    if (quotient !== 32'd14 || remainder !== 16'd2) begin
      errors++; $display("FAIL busy_results_held: got %0d/%0d exp 14/2", quotient, remainder);
    end
    // same check on the zero-divide path, where done is high in IDLE
    do_div("dz_then_start", 32'd1234, 16'd0, 1'b0);
    snap = done_cnt;
    repeat (3) @(posedge clock);
    @(negedge clock);
    exp_q.push_back(model(32'd600, 16'd0, 1'b0));
    in_dividend = 32'd600; in_divisor = 16'd0; start = 1'b1;
    @(posedge clock); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin @(posedge clock); #1; lat++; end
    in_dividend = 32'd50; in_divisor = 16'd5;
    @(posedge clock); #1 start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL dz_done_start_busy: got %b exp 0", busy); end
    check_result("dz_done_start");
    repeat (40) @(posedge clock);
    #1;
    vectors++;
    if (done_cnt - snap != 1) begin errors++; $display("FAIL dz_done_start_count: got %0d exp 1", done_cnt - snap); end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_div_by_zero;
`ifdef PARAM_DIVIDER_SIGNED_EN
    test_signed;
`endif
    test_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $finish;
  end

endmodule
